// File: rtl/reg_file_rename_pkg.sv
// Shared configuration for the rename register file: RoB index width,
// register index width, datapath width and the x0 index constant.
package reg_file_rename_pkg;

    localparam int ROB_W_DEF = 3;
    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;
    localparam int XLEN      = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_read_port.sv
// One source-operand read port of the rename register file.
// Resolves, in priority order: x0, not-busy committed value, optional
// same-cycle commit bypass (REG_COMMIT_BYPASS_EN), RoB ready probe, and
// finally reports the operand as pending on its producing tag.
module reg_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic [REG_IDX_W-1:0] ra,
    input  logic                 busy,
    input  logic [ROB_W-1:0]     tag,
    input  logic [XLEN-1:0]      value,
    input  logic                 rob_ready,
    input  logic [XLEN-1:0]      rob_val,
`ifdef REG_COMMIT_BYPASS_EN
    input  logic                 commit_valid,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_W-1:0]     commit_rob_id,
    input  logic [XLEN-1:0]      commit_value,
`endif
    output logic [XLEN-1:0]      val,
    output logic                 dep,
    output logic [ROB_W-1:0]     dep_tag,
    output logic [ROB_W-1:0]     rob_q
);

    // Combinational operand resolve; later branches only apply to a busy register.
    always_comb begin
        rob_q   = tag;
        val     = '0;
        dep     = 1'b0;
        dep_tag = '0;
        if (ra == REG_ZERO) begin
            val = '0;
        end else if (!busy) begin
            val = value;
        end
`ifdef REG_COMMIT_BYPASS_EN
        else if (commit_valid && (commit_rd == ra) && (commit_rob_id == tag)) begin
            val = commit_value;
        end
`endif
        else if (rob_ready) begin
            val = rob_val;
        end else begin
            dep     = 1'b1;
            dep_tag = tag;
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Write side takes the RoB issue stream (rd -> rob id) and commit stream
// (rd, rob id, value); clear flushes all rename state but keeps values.
// Read side is two combinational operand lookups (see reg_read_port).
// Optional macro REG_COMMIT_BYPASS_EN enables a same-cycle commit bypass on reads.
// Stream semantics: issue_valid/commit_valid are single-cycle qualifiers with
// no back-pressure; a transfer happens on any posedge where valid=1 and rdy=1.
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clear,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_W-1:0]     issue_rob_id,
    input  logic                 commit_valid,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_W-1:0]     commit_rob_id,
    input  logic [XLEN-1:0]      commit_value,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]      val1,
    output logic [XLEN-1:0]      val2,
    output logic                 dep1,
    output logic                 dep2,
    output logic [ROB_W-1:0]     tag1,
    output logic [ROB_W-1:0]     tag2,
    output logic [ROB_W-1:0]     rob_q1,
    output logic [ROB_W-1:0]     rob_q2,
    input  logic                 rob_ready1,
    input  logic                 rob_ready2,
    input  logic [XLEN-1:0]      rob_val1,
    input  logic [XLEN-1:0]      rob_val2
);

    logic [XLEN-1:0]  value_q [NREG];
    logic             busy_q  [NREG];
    logic [ROB_W-1:0] tag_q   [NREG];

    logic commit_en;
    logic issue_en;

    assign commit_en = rdy && commit_valid && (commit_rd != REG_ZERO);
    assign issue_en  = rdy && issue_valid && (issue_rd != REG_ZERO) && !clear;

    // State update: commit first, then clear or issue override busy/tag (issue wins on same rd).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            if (commit_en) begin
                value_q[commit_rd] <= commit_value;
                if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id))
                    busy_q[commit_rd] <= 1'b0;
            end
            if (clear) begin
                for (int i = 0; i < NREG; i++) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end
            end else if (issue_en) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_rob_id;
            end
        end
    end

    reg_read_port #(.ROB_W(ROB_W)) u_port1 (
        .ra            (rs1),
        .busy          (busy_q[rs1]),
        .tag           (tag_q[rs1]),
        .value         (value_q[rs1]),
        .rob_ready     (rob_ready1),
        .rob_val       (rob_val1),
`ifdef REG_COMMIT_BYPASS_EN
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
`endif
        .val           (val1),
        .dep           (dep1),
        .dep_tag       (tag1),
        .rob_q         (rob_q1)
    );

    reg_read_port #(.ROB_W(ROB_W)) u_port2 (
        .ra            (rs2),
        .busy          (busy_q[rs2]),
        .tag           (tag_q[rs2]),
        .value         (value_q[rs2]),
        .rob_ready     (rob_ready2),
        .rob_val       (rob_val2),
`ifdef REG_COMMIT_BYPASS_EN
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
`endif
        .val           (val2),
        .dep           (dep2),
        .dep_tag       (tag2),
        .rob_q         (rob_q2)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename. Each query pushes the hand-computed
// response of both read ports into exp_q; the monitor pops and compares on
// the falling edge while the query strobe is high.
module tb_reg_file_rename;
    import reg_file_rename_pkg::*;

    localparam int RW = 3;
    localparam int PW = XLEN + 1 + RW + RW;   // {val, dep, tag, rob_q}
    localparam int W  = 2 * PW;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 rdy = 1'b1;
    logic                 clear = 1'b0;
    logic                 issue_valid = 1'b0;
    logic [REG_IDX_W-1:0] issue_rd = '0;
    logic [RW-1:0]        issue_rob_id = '0;
    logic                 commit_valid = 1'b0;
    logic [REG_IDX_W-1:0] commit_rd = '0;
    logic [RW-1:0]        commit_rob_id = '0;
    logic [XLEN-1:0]      commit_value = '0;
    logic [REG_IDX_W-1:0] rs1 = '0;
    logic [REG_IDX_W-1:0] rs2 = '0;
    logic                 rob_ready1 = 1'b0;
    logic                 rob_ready2 = 1'b0;
    logic [XLEN-1:0]      rob_val1 = '0;
    logic [XLEN-1:0]      rob_val2 = '0;
    logic [XLEN-1:0]      val1, val2;
    logic                 dep1, dep2;
    logic [RW-1:0]        tag1, tag2, rob_q1, rob_q2;

    reg_file_rename #(.ROB_W(RW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_id(commit_rob_id), .commit_value(commit_value),
        .rs1(rs1), .rs2(rs2),
        .val1(val1), .val2(val2), .dep1(dep1), .dep2(dep2),
        .tag1(tag1), .tag2(tag2), .rob_q1(rob_q1), .rob_q2(rob_q2),
        .rob_ready1(rob_ready1), .rob_ready2(rob_ready2),
        .rob_val1(rob_val1), .rob_val2(rob_val2)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         q_valid = 1'b0;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [PW-1:0] pk(input logic [XLEN-1:0] v, input logic d,
                                         input logic [RW-1:0] t, input logic [RW-1:0] q);
        return {v, d, t, q};
    endfunction

    // Monitor: compare each port of the DUT against the oldest expectation
    always @(negedge clk) begin
        if (q_valid) begin
            logic [W-1:0]  e;
            logic [PW-1:0] a1, a2;
            string         n;
            checks = checks + 2;
            if (exp_q.size() == 0) begin
                errors = errors + 2;
                $display("FAIL %s: scoreboard empty while query strobe high", "monitor");
            end else begin
                e  = exp_q.pop_front();
                n  = name_q.pop_front();
                a1 = pk(val1, dep1, tag1, rob_q1);
                a2 = pk(val2, dep2, tag2, rob_q2);
                if (a1 !== e[W-1:PW]) begin
                    errors = errors + 1;
                    $display("FAIL %s port1: got val=%h dep=%b tag=%0d rob_q=%0d want val=%h dep=%b tag=%0d rob_q=%0d",
                             n, a1[PW-1:PW-XLEN], a1[2*RW], a1[2*RW-1:RW], a1[RW-1:0],
                             e[W-1:W-XLEN], e[PW+2*RW], e[PW+2*RW-1:PW+RW], e[PW+RW-1:PW]);
                end
                if (a2 !== e[PW-1:0]) begin
                    errors = errors + 1;
                    $display("FAIL %s port2: got val=%h dep=%b tag=%0d rob_q=%0d want val=%h dep=%b tag=%0d rob_q=%0d",
                             n, a2[PW-1:PW-XLEN], a2[2*RW], a2[2*RW-1:RW], a2[RW-1:0],
                             e[PW-1:PW-XLEN], e[2*RW], e[2*RW-1:RW], e[RW-1:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        clear        = 1'b0;
        rdy          = 1'b1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [RW-1:0] id);
        issue_valid = 1'b1; issue_rd = rd; issue_rob_id = id;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [RW-1:0] id, input logic [31:0] v);
        commit_valid = 1'b1; commit_rd = rd; commit_rob_id = id; commit_value = v;
    endtask

    task automatic query(input string n,
                         input logic [4:0] a1, input logic rr1, input logic [31:0] rv1,
                         input logic [4:0] a2, input logic rr2, input logic [31:0] rv2,
                         input logic [PW-1:0] e1, input logic [PW-1:0] e2);
        rs1 = a1; rob_ready1 = rr1; rob_val1 = rv1;
        rs2 = a2; rob_ready2 = rr2; rob_val2 = rv2;
        exp_q.push_back({e1, e2});
        name_q.push_back(n);
        q_valid = 1'b1;
        @(negedge clk);
        #1;
        q_valid = 1'b0;
        rob_ready1 = 1'b0;
        rob_ready2 = 1'b0;
    endtask

    localparam logic [PW-1:0] ZERO = '0;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        query("reset", 5'd5, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, ZERO, ZERO);

        // Issue rd5 -> rob3, then probe RoB miss and hit
        do_issue(5'd5, 3'd3); tick(); idle();
        query("busy_miss", 5'd5, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
              pk(32'h0, 1'b1, 3'd3, 3'd3), ZERO);
        query("busy_probe", 5'd5, 1'b1, 32'h1234, 5'd0, 1'b1, 32'hFFFF,
              pk(32'h1234, 1'b0, 3'd0, 3'd3), ZERO);

        // Double rename of rd7; the older commit must not clear busy
        do_issue(5'd7, 3'd2); tick();
        do_issue(5'd7, 3'd4); tick(); idle();
        do_commit(5'd7, 3'd2, 32'hAA); tick(); idle();
        query("old_commit", 5'd7, 1'b0, 32'h0, 5'd5, 1'b0, 32'h0,
              pk(32'h0, 1'b1, 3'd4, 3'd4), pk(32'h0, 1'b1, 3'd3, 3'd3));
        do_commit(5'd7, 3'd4, 32'hBB); tick(); idle();
        query("new_commit", 5'd7, 1'b0, 32'h0, 5'd7, 1'b1, 32'hDEAD,
              pk(32'hBB, 1'b0, 3'd0, 3'd4), pk(32'hBB, 1'b0, 3'd0, 3'd4));

        // Same-cycle issue and commit on rd9
        do_issue(5'd9, 3'd1); tick(); idle();
        do_issue(5'd9, 3'd6); do_commit(5'd9, 3'd1, 32'h55); tick(); idle();
        query("issue_wins", 5'd9, 1'b0, 32'h0, 5'd9, 1'b1, 32'h77,
              pk(32'h0, 1'b1, 3'd6, 3'd6), pk(32'h77, 1'b0, 3'd0, 3'd6));

        // rdy=0 holds state even with clear asserted
        do_issue(5'd11, 3'd3); tick(); idle();
        rdy = 1'b0; clear = 1'b1; tick(); idle();
        query("rdy0_clear", 5'd11, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
              pk(32'h0, 1'b1, 3'd3, 3'd3), ZERO);

        // Clear with concurrent issue (dropped) and commit (kept)
        do_issue(5'd1, 3'd1); tick();
        do_issue(5'd2, 3'd2); tick();
        do_issue(5'd3, 3'd3); tick(); idle();
        clear = 1'b1; do_issue(5'd4, 3'd5); do_commit(5'd1, 3'd1, 32'h77); tick(); idle();
        query("clear_r1_r4", 5'd1, 1'b0, 32'h0, 5'd4, 1'b0, 32'h0,
              pk(32'h77, 1'b0, 3'd0, 3'd0), ZERO);
        query("clear_r2_r3", 5'd2, 1'b0, 32'h0, 5'd3, 1'b0, 32'h0, ZERO, ZERO);
        query("clear_r9_r7", 5'd9, 1'b0, 32'h0, 5'd7, 1'b0, 32'h0,
              pk(32'h55, 1'b0, 3'd0, 3'd0), pk(32'hBB, 1'b0, 3'd0, 3'd0));
        query("clear_r11", 5'd11, 1'b0, 32'h0, 5'd5, 1'b0, 32'h0, ZERO, ZERO);

        // rdy=0 blocks issue and commit
        rdy = 1'b0; do_issue(5'd8, 3'd1); do_commit(5'd8, 3'd1, 32'h99); tick(); idle();
        query("rdy0_hold", 5'd8, 1'b0, 32'h0, 5'd8, 1'b1, 32'h12,
              ZERO, ZERO);

        // x0 ignores issue and commit, reads stay zero
        do_issue(5'd0, 3'd5); do_commit(5'd0, 3'd5, 32'hDEAD); tick(); idle();
        query("x0", 5'd0, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, ZERO, ZERO);

        // Same-cycle commit of a busy register's producer
        do_issue(5'd10, 3'd2); tick(); idle();
        do_commit(5'd10, 3'd2, 32'h42);
`ifdef REG_COMMIT_BYPASS_EN
        query("bypass", 5'd10, 1'b0, 32'h0, 5'd10, 1'b1, 32'h66,
              pk(32'h42, 1'b0, 3'd0, 3'd2), pk(32'h42, 1'b0, 3'd0, 3'd2));
`else
        query("no_bypass", 5'd10, 1'b0, 32'h0, 5'd10, 1'b1, 32'h66,
              pk(32'h0, 1'b1, 3'd2, 3'd2), pk(32'h66, 1'b0, 3'd0, 3'd2));
`endif
        tick(); idle();
        query("after_commit", 5'd10, 1'b0, 32'h0, 5'd1, 1'b0, 32'h0,
              pk(32'h42, 1'b0, 3'd0, 3'd2), pk(32'h77, 1'b0, 3'd0, 3'd0));

        // Reset clears committed values
        rst = 1'b1; tick(); rst = 1'b0;
        query("reset2", 5'd1, 1'b0, 32'h0, 5'd9, 1'b0, 32'h0, ZERO, ZERO);

        repeat (2) @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
